// File: rtl/counter_4bit.sv
// Purpose: WIDTH-bit up/down counter with synchronous parallel load and async active-low clear.
// Latency: Count_out updates one clk edge after Load/Count_en are sampled; reset clears it at once.
// Backpressure: none; the counter has no handshake and every rising edge is accepted.
module counter_4bit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             nReset,
    input  logic             Load,
    input  logic             Count_en,
    input  logic             Up,
    input  logic [WIDTH-1:0] Count_in,
    output logic [WIDTH-1:0] Count_out
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Load beats counting, counting beats hold; wrap-around falls out of the modulo arithmetic.
    always_comb begin
        count_d = count_q;
        if (Load) begin
            count_d = Count_in;
        end else if (Count_en) begin
            if (Up) begin
                count_d = count_q + WIDTH'(1);
            end else begin
                count_d = count_q - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign Count_out = count_q;

endmodule

// File: tb/tb_counter_4bit.sv
// Directed bench for counter_4bit: load priority, hold, up/down counting, wrap, async reset.
module tb_counter_4bit;

    logic       clk;
    logic       nReset;
    logic       Load;
    logic       Count_en;
    logic       Up;
    logic [3:0] Count_in;
    logic [3:0] Count_out;

    int checks = 0;
    int errors = 0;

    counter_4bit #(.WIDTH(4)) dut (
        .clk       (clk),
        .nReset    (nReset),
        .Load      (Load),
        .Count_en  (Count_en),
        .Up        (Up),
        .Count_in  (Count_in),
        .Count_out (Count_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [3:0] expected);
        checks++;
        assert (Count_out === expected)
        else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, Count_out, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        nReset   = 1'b0;
        Load     = 1'b0;
        Count_en = 1'b0;
        Up       = 1'b0;
        Count_in = 4'b0000;
        #1;
        check("reset_before_edge", 4'b0000);

        // Active inputs while reset is held must be ignored.
        Load     = 1'b1;
        Count_en = 1'b1;
        Up       = 1'b1;
        Count_in = 4'b0110;
        step();
        check("reset_ignores_load", 4'b0000);

        // Load overrides count.
        nReset   = 1'b1;
        Count_in = 4'b1010;
        step();
        check("load_over_count", 4'b1010);

        Load     = 1'b0;
        Count_en = 1'b0;
        step();
        check("hold", 4'b1010);

        Count_en = 1'b1;
        Up       = 1'b0;
        step();
        check("down_1", 4'b1001);
        step();
        check("down_2", 4'b1000);

        Up = 1'b1;
        step();
        check("up_1", 4'b1001);
        step();
        check("up_2", 4'b1010);

        // Pulses between edges must not reach the register.
        Load     = 1'b1;
        Count_in = 4'b0000;
        #2;
        Load     = 1'b0;
        Count_en = 1'b0;
        #1;
        check("glitch_no_effect", 4'b1010);
        step();
        check("glitch_then_hold", 4'b1010);

        // Load with Up=0, then count down.
        Load     = 1'b1;
        Count_en = 1'b1;
        Up       = 1'b0;
        Count_in = 4'b1010;
        step();
        check("load_up0", 4'b1010);
        Load = 1'b0;
        step();
        check("down_after_load", 4'b1001);

        // Async reset mid-operation.
        Load     = 1'b1;
        Count_in = 4'b0011;
        step();
        check("load_0011", 4'b0011);
        #2;
        nReset = 1'b0;
        #1;
        check("async_reset_1", 4'b0000);
        step();
        check("reset_held_over_edge", 4'b0000);

        nReset   = 1'b1;
        Count_in = 4'b1101;
        Up       = 1'b0;
        step();
        check("load_1101", 4'b1101);
        #2;
        nReset = 1'b0;
        #1;
        check("async_reset_2", 4'b0000);
        #2;
        nReset = 1'b1;

        // Wrap up and down.
        Load     = 1'b1;
        Count_in = 4'b1111;
        step();
        check("load_1111", 4'b1111);
        Load = 1'b0;
        Up   = 1'b1;
        step();
        check("wrap_up", 4'b0000);

        Load     = 1'b1;
        Count_in = 4'b0000;
        Up       = 1'b0;
        step();
        check("load_0000", 4'b0000);
        Load = 1'b0;
        step();
        check("wrap_down", 4'b1111);
        step();
        check("down_after_wrap", 4'b1110);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
